// File: rtl/fifo_mon_pkg.sv
// Shared types and constants for the FIFO protocol/occupancy monitor.
package fifo_mon_pkg;

   localparam int CODE_W    = 3;
   localparam int NUM_CODES = 5;

   // Error codes reported in the first-error record.
   typedef enum logic [CODE_W-1:0] {
      NONE      = 3'd0,
      OVERFLOW  = 3'd1,
      UNDERFLOW = 3'd2,
      COUNT_MM  = 3'd3,
      FULL_MM   = 3'd4,
      EMPTY_MM  = 3'd5
   } err_code_t;

   // Bit positions inside one channel's 5-bit slice of err_flags.
   localparam int BIT_OVERFLOW  = 0;
   localparam int BIT_UNDERFLOW = 1;
   localparam int BIT_COUNT_MM  = 2;
   localparam int BIT_FULL_MM   = 3;
   localparam int BIT_EMPTY_MM  = 4;

   // Lowest-numbered code present in a channel's event vector.
   function automatic err_code_t first_code(input logic [NUM_CODES-1:0] ev);
      if (ev[BIT_OVERFLOW])       return OVERFLOW;
      else if (ev[BIT_UNDERFLOW]) return UNDERFLOW;
      else if (ev[BIT_COUNT_MM])  return COUNT_MM;
      else if (ev[BIT_FULL_MM])   return FULL_MM;
      else if (ev[BIT_EMPTY_MM])  return EMPTY_MM;
      else                        return NONE;
   endfunction

endpackage

// File: rtl/fifo_mon_channel.sv
// One monitored FIFO channel: shadow occupancy, accept rules, event detection
// and optional resynchronisation of the shadow from the DUT count.
module fifo_mon_channel
   import fifo_mon_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1,
   parameter bit RESYNC = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic                 full,
   input  logic                 empty,
   input  logic [CNT_W-1:0]     count,
   output logic [NUM_CODES-1:0] events
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] base;
   logic [CNT_W-1:0] shadow_nxt;
   logic             wr_acc;
   logic             rd_acc;

   // Compare sampled DUT signals against the shadow and compute the next shadow.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      events     = '0;
      base       = shadow;
      wr_acc     = 1'b0;
      rd_acc     = 1'b0;
      shadow_nxt = shadow;

      events[BIT_OVERFLOW]  = wr_en && full;
      events[BIT_UNDERFLOW] = rd_en && empty;
      events[BIT_COUNT_MM]  = (count != shadow);
      events[BIT_FULL_MM]   = (full  != (shadow == DEPTH_C));
      events[BIT_EMPTY_MM]  = (empty != (shadow == '0));

      // On a count mismatch the DUT count becomes the reference, so one
      // disagreement does not turn into a mismatch on every later cycle.
      if (RESYNC && events[BIT_COUNT_MM])
         base = count;

      wr_acc     = wr_en && (base < DEPTH_C);
      rd_acc     = rd_en && (base != '0);
      shadow_nxt = base + CNT_W'(wr_acc) - CNT_W'(rd_acc);
   end

   // Shadow occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         shadow <= '0;
      else
         // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
         shadow <= shadow_nxt;
   end

endmodule

// File: rtl/fifo_protocol_monitor.sv
// Multi-channel FIFO protocol monitor: per-channel checkers plus sticky error
// flags, saturating error-cycle counter, timestamp and first-error capture.
module fifo_protocol_monitor
   import fifo_mon_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DEPTH    = 16,
   parameter int CNT_W    = $clog2(DEPTH) + 1,
   parameter int ERRCNT_W = 16,
   parameter int TS_W     = 32,
   parameter bit RESYNC   = 1'b1,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic [NUM_CH-1:0]           wr_en,
   input  logic [NUM_CH-1:0]           rd_en,
   input  logic [NUM_CH-1:0]           full,
   input  logic [NUM_CH-1:0]           empty,
   input  logic [NUM_CH*CNT_W-1:0]     count,
   output logic [NUM_CH*NUM_CODES-1:0] err_flags,
   output logic                        err_any,
   output logic [ERRCNT_W-1:0]         err_count,
   output logic                        first_err_valid,
   output logic [CH_W-1:0]             first_err_ch,
   output logic [CODE_W-1:0]           first_err_code,
   output logic [TS_W-1:0]             first_err_time
);

   logic [NUM_CH*NUM_CODES-1:0] ev;
   logic                        any_ev;
   logic [CH_W-1:0]             pick_ch;
   err_code_t                   pick_code;
   logic                        found;
   logic [ERRCNT_W-1:0]         cnt_base;
   logic [ERRCNT_W-1:0]         cnt_nxt;
   logic [TS_W-1:0]             ts;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fifo_mon_channel #(
         .DEPTH  (DEPTH),
         .CNT_W  (CNT_W),
         .RESYNC (RESYNC)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (wr_en[i]),
         .rd_en  (rd_en[i]),
         .full   (full[i]),
         .empty  (empty[i]),
         .count  (count[i*CNT_W +: CNT_W]),
         .events (ev[i*NUM_CODES +: NUM_CODES])
      );
   end

   // Pick the reported event (lowest channel, then lowest code) and the next error count.
   always_comb begin
      any_ev    = |ev;
      pick_ch   = '0;
      pick_code = NONE;
      found     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && (|ev[i*NUM_CODES +: NUM_CODES])) begin
            pick_ch   = CH_W'(i);
            pick_code = first_code(ev[i*NUM_CODES +: NUM_CODES]);
            found     = 1'b1;
         end
      end
      // A clear cycle counts from zero, so an event in that cycle yields a count of 1.
      cnt_base = clear ? '0 : err_count;
      cnt_nxt  = (any_ev && (cnt_base != '1)) ? cnt_base + ERRCNT_W'(1) : cnt_base;
   end

   // Sticky flags, error counter, timestamp and first-error record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts              <= '0;
         err_flags       <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_ch    <= '0;
         first_err_code  <= '0;
         first_err_time  <= '0;
      end else begin
         ts        <= ts + TS_W'(1);
         err_flags <= (clear ? '0 : err_flags) | ev;
         err_count <= cnt_nxt;
         if (any_ev && (clear || !first_err_valid)) begin
            first_err_valid <= 1'b1;
            first_err_ch    <= pick_ch;
            first_err_code  <= pick_code;
            first_err_time  <= ts;
         end else if (clear) begin
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_code  <= '0;
            first_err_time  <= '0;
         end
      end
   end

   assign err_any = |err_flags;

endmodule
